cp_remover: RTL and testbench
=============================

Name: cp_remover

Overview:
- Receive-side counterpart of the transmit guard-interval insertion stage.
- Accepts a stream of complex time-domain samples, one per beat. Each OFDM symbol is CP_LEN cyclic-prefix samples followed by FFT_LEN body samples.
- Discards the prefix and forwards only the FFT_LEN body samples, with start/end-of-symbol markers, to the receive FFT.
- Valid/ready on both sides; single output register stage.

Parameters:
- DW, 16, width of each real/imag sample (signed two's complement).
- FFT_LEN, 64, body samples per symbol forwarded to FFT (>=2).
- CP_LEN, 16, prefix samples discarded per symbol (>=1, < FFT_LEN).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept input sample this cycle.
- in_real  in  DW  input sample real part.
- in_imag  in  DW  input sample imag part.
- in_sos  in  1  qualifies current input beat as first prefix sample of a symbol (from timing sync).
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output sample.
- out_real  out  DW  body sample real part, bit-exact copy of input.
- out_imag  out  DW  body sample imag part, bit-exact copy of input.
- out_sof  out  1  marks body sample index 0.
- out_eof  out  1  marks body sample index FFT_LEN-1.
- sym_count  out  16  completed symbols forwarded, wraps 65535->0.
- resync_err  out  1  one-cycle pulse: in_sos seen outside expected symbol boundary.

Behaviour:
- Reset values, all outputs: out_valid=0, out_real=0, out_imag=0, out_sof=0, out_eof=0, sym_count=0, resync_err=0.
- After reset: FSM in SEARCH, sample counter cnt=0.
- Beat = in_valid & in_ready.
- in_ready:
  - 1 in SEARCH and DROP.
  - In PASS: in_ready = !out_valid | out_ready.
  - Combinational on state, out_valid and out_ready only; never depends on in_valid.
- FSM:
  - SEARCH: beats without in_sos are discarded. A beat with in_sos counts as prefix sample 0; cnt=1, go to DROP. If CP_LEN==1, go directly to PASS with cnt=0.
  - DROP: each beat is discarded and cnt increments. The beat with cnt==CP_LEN-1 moves to PASS with cnt=0.
  - PASS: each beat is loaded into the output register and cnt increments.
    - Loaded beat gets out_sof=(cnt==0) and out_eof=(cnt==FFT_LEN-1).
    - The beat with cnt==FFT_LEN-1 moves to DROP with cnt=0 (next symbol assumed contiguous) and increments sym_count.
- in_sos handling:
  - in_sos on a beat in DROP with cnt==0 is expected and silent.
  - in_sos on any other beat in DROP or PASS is a resync:
    - resync_err pulses the next cycle.
    - The beat is treated as prefix sample 0 (cnt=1, state DROP).
    - A partially forwarded symbol is abandoned: no eof is emitted and sym_count is not incremented.
    - Samples already in the output register still drain normally.
  - in_sos without in_valid is ignored.
- Output register:
  - Latency: an accepted body beat appears on out_* the next cycle.
  - out_valid sets on a PASS beat.
  - out_valid clears when out_ready=1 and there is no new PASS beat in the same cycle.
  - Simultaneous drain and load in the same cycle gives back-to-back throughput of 1 sample/cycle.
  - While out_valid=1 and out_ready=0, out_* hold stable.
- Downstream stall in DROP:
  - Input keeps flowing; prefix samples do not need the output register.
  - The pending output beat is held.
- Reset mid-symbol: immediate return to reset values and SEARCH; the partial symbol is lost.
- Counter widths: cnt is ceil(log2(max(FFT_LEN,CP_LEN))) bits. No arithmetic on data path.

Test Plan:
- Basic: rst_n low 3 cycles, then 2 contiguous symbols of 80 beats (in_sos on beat 0 and beat 80), in_real=beat index, out_ready=1 -> 128 outputs.
  - Values 16..79 then 96..159.
  - out_sof at values 16 and 96; out_eof at values 79 and 159.
  - sym_count=2, resync_err never.
- Pre-sync junk: 10 beats without in_sos, then one symbol -> junk fully dropped; exactly 64 outputs, first is beat index 26.
- Backpressure: out_ready toggles 1,0,0,1 repeating with constant in_valid.
  - Output sequence identical to the basic test, no loss or duplicates.
  - out_* stable while stalled.
  - in_ready=1 for all 16 prefix beats of symbol 2.
- Resync: in_sos on body beat 40 of symbol 1 ->
  - resync_err pulse.
  - Symbol 1 truncated with no eof; sym_count unchanged.
  - The new symbol starting at that beat forwards 64 samples with sof/eof; sym_count=1.
- Gaps: in_valid deasserted randomly 30% of cycles -> same output values as the basic test; no extra sof/eof.
- Async reset: rst_n low during PASS beat 20, without a clock edge -> out_valid, out_sof, out_eof and sym_count read 0 immediately. After release, beats without in_sos are discarded.

Source files
------------

// File: rtl/cp_remover.sv
// cp_remover: receive-side cyclic-prefix removal.
// Drops CP_LEN prefix samples of every OFDM symbol and forwards the FFT_LEN
// body samples, tagged with start/end-of-symbol markers, through a single
// valid/ready output register stage.
module cp_remover #(
  parameter int DW      = 16,
  parameter int FFT_LEN = 64,
  parameter int CP_LEN  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic          in_sos,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic          out_sof,
  output logic          out_eof,
  output logic [15:0]   sym_count,
  output logic          resync_err
);

  // Sample counter is sized for the longer of the two segments.
  localparam int MAXLEN = (FFT_LEN > CP_LEN) ? FFT_LEN : CP_LEN;
  localparam int CW     = $clog2(MAXLEN);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CP_LAST  = CW'(CP_LEN - 1);
  localparam logic [CW-1:0] FFT_LAST = CW'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_DROP   = 2'd1,
    ST_PASS   = 2'd2
  } state_t;

  // A symbol start counts as prefix sample 0; with a one-sample prefix the
  // very next beat is already body sample 0.
  localparam state_t        START_ST  = (CP_LEN == 1) ? ST_PASS : ST_DROP;
  localparam logic [CW-1:0] START_CNT = (CP_LEN == 1) ? CNT_ZERO : CNT_ONE;

  state_t        state_r;
  logic [CW-1:0] cnt_r;

  logic          beat_s;
  logic          sos_beat_s;
  logic          resync_s;
  logic          load_s;
  logic [CW-1:0] cnt_inc_s;

  // Input acceptance: prefix/search beats never need the output register,
  // body beats need a free (or simultaneously draining) output slot.
  always_comb begin
    in_ready = 1'b1;
    case (state_r)
      ST_SEARCH: in_ready = 1'b1;
      ST_DROP:   in_ready = 1'b1;
      ST_PASS:   in_ready = ~out_valid | out_ready;
      default:   in_ready = 1'b1;
    endcase
  end

  assign beat_s     = in_valid & in_ready;
  assign sos_beat_s = beat_s & in_sos;
  assign cnt_inc_s  = cnt_r + CNT_ONE;

  // A symbol start anywhere except the expected boundary (DROP, cnt 0) is a
  // loss of timing alignment; SEARCH starts are the normal acquisition path.
  assign resync_s = sos_beat_s &
                    (((state_r == ST_DROP) && (cnt_r != CNT_ZERO)) ||
                     (state_r == ST_PASS));

  // Body beats are loaded unless they restart the symbol.
  assign load_s = beat_s & (state_r == ST_PASS) & ~in_sos;

  // Symbol framing FSM with sample counter, completed-symbol counter and
  // resync pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_SEARCH;
      cnt_r      <= CNT_ZERO;
      sym_count  <= 16'd0;
      resync_err <= 1'b0;
    end else begin
      resync_err <= resync_s;
      case (state_r)
        ST_SEARCH: begin
          if (sos_beat_s) begin
            state_r <= START_ST;
            cnt_r   <= START_CNT;
          end else begin
            state_r <= ST_SEARCH;
            cnt_r   <= CNT_ZERO;
          end
        end
        ST_DROP: begin
          if (resync_s) begin
            state_r <= START_ST;
            cnt_r   <= START_CNT;
          end else if (beat_s) begin
            if (cnt_r == CP_LAST) begin
              state_r <= ST_PASS;
              cnt_r   <= CNT_ZERO;
            end else begin
              state_r <= ST_DROP;
              cnt_r   <= cnt_inc_s;
            end
          end else begin
            state_r <= ST_DROP;
            cnt_r   <= cnt_r;
          end
        end
        ST_PASS: begin
          if (resync_s) begin
            // Partial symbol abandoned: no eof, no symbol count.
            state_r <= START_ST;
            cnt_r   <= START_CNT;
          end else if (load_s) begin
            if (cnt_r == FFT_LAST) begin
              // Next symbol assumed contiguous: its prefix follows directly.
              state_r   <= ST_DROP;
              cnt_r     <= CNT_ZERO;
              sym_count <= sym_count + 16'd1;
            end else begin
              state_r <= ST_PASS;
              cnt_r   <= cnt_inc_s;
            end
          end else begin
            state_r <= ST_PASS;
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r <= ST_SEARCH;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Output register: load on a body beat, empty on drain without reload,
  // hold everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_real  <= {DW{1'b0}};
      out_imag  <= {DW{1'b0}};
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (load_s) begin
      out_valid <= 1'b1;
      out_real  <= in_real;
      out_imag  <= in_imag;
      out_sof   <= (cnt_r == CNT_ZERO);
      out_eof   <= (cnt_r == FFT_LAST);
    end else if (out_ready) begin
      // Drained with nothing new: clear markers so none look stale.
      out_valid <= 1'b0;
      out_real  <= out_real;
      out_imag  <= out_imag;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= out_valid;
      out_real  <= out_real;
      out_imag  <= out_imag;
      out_sof   <= out_sof;
      out_eof   <= out_eof;
    end
  end

endmodule

// File: tb/tb_cp_remover.sv
// tb_cp_remover: directed self-checking bench for cp_remover.
// Beats carry their index as in_real and its inverse as in_imag; expected
// body samples are generated from symbol start positions.
module tb_cp_remover;

  localparam int DW      = 16;
  localparam int FFT_LEN = 64;
  localparam int CP_LEN  = 16;
  localparam int SYM     = FFT_LEN + CP_LEN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  logic          in_sos;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_imag;
  logic          out_sof;
  logic          out_eof;
  logic [15:0]   sym_count;
  logic          resync_err;

  cp_remover #(.DW(DW), .FFT_LEN(FFT_LEN), .CP_LEN(CP_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_sos(in_sos),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_sof(out_sof), .out_eof(out_eof),
    .sym_count(sym_count), .resync_err(resync_err)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  int          n_resync = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  bit          gap_mode = 1'b0;
  bit          acc;
  int          last_wait;
  bit          hold_pending = 1'b0;
  logic [34:0] held;

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: sample at negedge, advance past posedge, update out_ready.
  task automatic tick();
    logic [34:0] cur;
    @(negedge clk);
    cur = {out_valid, out_sof, out_eof, out_imag, out_real};
    if (hold_pending) check("stall_hold", cur, held);
    hold_pending = out_valid && !out_ready;
    held = cur;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) got_q.push_back(cur[33:0]);
    if (resync_err === 1'b1) n_resync++;
    @(posedge clk);
    #1;
    cyc++;
    out_ready = (rdy_mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
  endtask

  // Present one beat until accepted (bounded), with optional idle gaps.
  task automatic send(input int v, input bit sos);
    if (gap_mode) begin
      while ($urandom_range(0, 99) < 30) begin
        in_valid = 1'b0;
        in_sos   = 1'($urandom_range(0, 1));
        in_real  = 16'($urandom_range(0, 65535));
        tick();
      end
    end
    in_valid  = 1'b1;
    in_real   = v[DW-1:0];
    in_imag   = ~v[DW-1:0];
    in_sos    = sos;
    last_wait = 0;
    tick();
    while (!acc && last_wait < 100) begin
      last_wait++;
      tick();
    end
    if (!acc) check("accept_timeout", 35'(acc), 35'd1);
    in_valid = 1'b0;
    in_sos   = 1'b0;
  endtask

  // Idle cycles to let the output register empty.
  task automatic drain(input int n);
    in_valid = 1'b0;
    in_sos   = 1'b0;
    repeat (n) tick();
  endtask

  // Expected body samples of a symbol whose prefix starts at beat s.
  task automatic exp_sym(input int s, input int nbody, input bit with_eof);
    logic [15:0] v;
    for (int k = 0; k < nbody; k++) begin
      v = 16'(s + CP_LEN + k);
      exp_q.push_back({(k == 0), (with_eof && (k == FFT_LEN - 1)), ~v, v});
    end
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_count"}, 35'(got_q.size()), 35'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, 35'(got_q[i]), 35'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_sos    = 1'b0;
    out_ready = 1'b1;
    rdy_mode  = 0;
    gap_mode  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    n_resync     = 0;
    hold_pending = 1'b0;
    cyc          = 0;
  endtask

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Directed test sequence.
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sos = 1'b0;
    in_real = '0; in_imag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 35'(out_valid), 35'd0);
    check("rst_out_real", 35'(out_real), 35'd0);
    check("rst_out_imag", 35'(out_imag), 35'd0);
    check("rst_out_sof", 35'(out_sof), 35'd0);
    check("rst_out_eof", 35'(out_eof), 35'd0);
    check("rst_sym_count", 35'(sym_count), 35'd0);
    check("rst_resync_err", 35'(resync_err), 35'd0);
    check("rst_in_ready", 35'(in_ready), 35'd1);
    rst_n = 1'b1;

    // Basic: two contiguous symbols.
    for (int i = 0; i < 2 * SYM; i++) send(i, (i % SYM) == 0);
    drain(8);
    exp_sym(0, FFT_LEN, 1'b1);
    exp_sym(SYM, FFT_LEN, 1'b1);
    compare("basic");
    check("basic_sym_count", 35'(sym_count), 35'd2);
    check("basic_resync", 35'(n_resync), 35'd0);

    // Pre-sync junk: 10 beats without sos, then a symbol from beat 10.
    do_reset();
    for (int i = 0; i < 10 + SYM; i++) send(i, i == 10);
    drain(8);
    exp_sym(10, FFT_LEN, 1'b1);
    compare("junk");
    check("junk_sym_count", 35'(sym_count), 35'd1);

    // Backpressure: out_ready 1,0,0,1 repeating.
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 2 * SYM; i++) begin
      send(i, (i % SYM) == 0);
      if (i >= SYM && i < SYM + CP_LEN) check("bp_prefix_wait", 35'(last_wait), 35'd0);
    end
    drain(12);
    exp_sym(0, FFT_LEN, 1'b1);
    exp_sym(SYM, FFT_LEN, 1'b1);
    compare("bp");
    check("bp_sym_count", 35'(sym_count), 35'd2);

    // Resync on body beat 40 of symbol 1 (beat index 56).
    do_reset();
    for (int i = 0; i < 56 + SYM; i++) send(i, (i == 0) || (i == 56));
    drain(8);
    exp_sym(0, 40, 1'b0);
    exp_sym(56, FFT_LEN, 1'b1);
    compare("resync");
    check("resync_sym_count", 35'(sym_count), 35'd1);
    check("resync_pulses", 35'(n_resync), 35'd1);

    // Random input gaps with spurious sos on idle cycles.
    do_reset();
    gap_mode = 1'b1;
    for (int i = 0; i < 2 * SYM; i++) send(i, (i % SYM) == 0);
    gap_mode = 1'b0;
    drain(8);
    exp_sym(0, FFT_LEN, 1'b1);
    exp_sym(SYM, FFT_LEN, 1'b1);
    compare("gaps");
    check("gaps_sym_count", 35'(sym_count), 35'd2);
    check("gaps_resync", 35'(n_resync), 35'd0);

    // Asynchronous reset at body beat 20 of symbol 2 (beat index 116).
    do_reset();
    for (int i = 0; i <= SYM + CP_LEN + 20; i++) send(i, (i % SYM) == 0);
    check("arst_pre_valid", 35'(out_valid), 35'd1);
    check("arst_pre_sym_count", 35'(sym_count), 35'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 35'(out_valid), 35'd0);
    check("arst_out_sof", 35'(out_sof), 35'd0);
    check("arst_out_eof", 35'(out_eof), 35'd0);
    check("arst_sym_count", 35'(sym_count), 35'd0);
    check("arst_out_real", 35'(out_real), 35'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    hold_pending = 1'b0;
    for (int i = 0; i < 10; i++) send(200 + i, 1'b0);
    drain(4);
    check("arst_post_outputs", 35'(got_q.size()), 35'd0);
    check("arst_post_valid", 35'(out_valid), 35'd0);
    check("arst_post_sym_count", 35'(sym_count), 35'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
